// File: rtl/bus_arbiter_split_pkg.sv
// Shared types and helpers for the split-capable system-bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GRANT    = 2'd1,
        ARB_HANDOVER = 2'd2
    } arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_SLAVES  = 8;

    // Index width that never collapses to zero bits for a single-entry set.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_split_if.sv
// Arbitration signals between masters, slaves, address decoder and the arbiter.
interface bus_arbiter_split_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4
) ();

    logic [NUM_MASTERS-1:0]          breq;
    logic [idx_w(NUM_SLAVES)-1:0]    sel_slave;
    logic [NUM_SLAVES-1:0]           slave_split;
    logic [NUM_SLAVES-1:0]           split_release;
    logic [NUM_MASTERS-1:0]          bgrant;
    logic [NUM_MASTERS-1:0]          split;
    logic [idx_w(NUM_MASTERS)-1:0]   owner;
    logic                            owner_valid;
    logic                            hold_timeout;

    // Bus side: masters, slaves and decoder drive requests and split events.
    modport master (
        output breq, sel_slave, slave_split, split_release,
        input  bgrant, split, owner, owner_valid, hold_timeout
    );

    // Arbiter side: answers requests with grants and split status.
    modport slave (
        input  breq, sel_slave, slave_split, split_release,
        output bgrant, split, owner, owner_valid, hold_timeout
    );

endinterface

// File: rtl/bus_arbiter_split_rr_picker.sv
// Combinational picker: first set bit of req, either from index 0 or
// rotating from start_idx with wrap-around.
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start_idx,
    input  logic          rr_en,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = rr_en ? IW'((int'(start_idx) + i) % N) : IW'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_split.sv
// Bus arbiter for NUM_MASTERS masters with round-robin/fixed priority,
// split-transaction parking/resume and an optional contention hold limit.
module bus_arbiter_split
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter bit RR_EN       = 1'b1,
    parameter int MAX_HOLD    = 0
) (
    input  logic                clk,
    input  logic                rst,
    bus_arbiter_split_if.slave  bus
);

    localparam int MW = idx_w(NUM_MASTERS);
    localparam int SW = idx_w(NUM_SLAVES);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;
    localparam logic [MW-1:0] LAST_IDX  = MW'(NUM_MASTERS - 1);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_masters
        $error("bus_arbiter_split: NUM_MASTERS out of range");
    end
    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_slaves
        $error("bus_arbiter_split: NUM_SLAVES out of range");
    end

    arb_state_t             state, state_nxt;
    logic [NUM_MASTERS-1:0] bgrant, bgrant_nxt;
    logic [NUM_MASTERS-1:0] split_pending, split_pending_nxt;
    logic [NUM_MASTERS-1:0] resume, resume_nxt;
    logic [SW-1:0]          split_slave     [NUM_MASTERS];
    logic [SW-1:0]          split_slave_nxt [NUM_MASTERS];
    logic [MW-1:0]          owner, owner_nxt;
    logic [MW-1:0]          last_owner, last_owner_nxt;
    logic                   owner_valid, owner_valid_nxt;
    logic                   hold_timeout, hold_timeout_nxt;
    logic [HW-1:0]          hold_cnt, hold_cnt_nxt;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] released;
    logic [MW-1:0]          rr_start;
    logic                   res_found, elg_found;
    logic [MW-1:0]          res_idx, elg_idx, winner;
    logic                   split_hit;
    logic                   contended;

    assign eligible  = bus.breq & ~split_pending;
    assign rr_start  = (last_owner == LAST_IDX) ? '0 : last_owner + MW'(1);
    assign split_hit = bus.slave_split[bus.sel_slave];
    assign contended = |(eligible & ~bgrant);
    assign winner    = res_found ? res_idx : elg_idx;

    // Releases look only at entries recorded before this edge.
    always_comb begin
        released = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            released[m] = split_pending[m] & bus.split_release[split_slave[m]];
        end
    end

    rr_picker #(.N(NUM_MASTERS), .IW(MW)) u_pick_resume (
        .req       (resume & eligible),
        .start_idx ('0),
        .rr_en     (1'b0),
        .found     (res_found),
        .idx       (res_idx)
    );

    rr_picker #(.N(NUM_MASTERS), .IW(MW)) u_pick_eligible (
        .req       (eligible),
        .start_idx (rr_start),
        .rr_en     (RR_EN),
        .found     (elg_found),
        .idx       (elg_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ARB_IDLE;
            bgrant        <= '0;
            split_pending <= '0;
            resume        <= '0;
            owner         <= '0;
            last_owner    <= LAST_IDX;
            owner_valid   <= 1'b0;
            hold_timeout  <= 1'b0;
            hold_cnt      <= '0;
            for (int m = 0; m < NUM_MASTERS; m++) split_slave[m] <= '0;
        end else begin
            state         <= state_nxt;
            bgrant        <= bgrant_nxt;
            split_pending <= split_pending_nxt;
            resume        <= resume_nxt;
            owner         <= owner_nxt;
            last_owner    <= last_owner_nxt;
            owner_valid   <= owner_valid_nxt;
            hold_timeout  <= hold_timeout_nxt;
            hold_cnt      <= hold_cnt_nxt;
            for (int m = 0; m < NUM_MASTERS; m++) split_slave[m] <= split_slave_nxt[m];
        end
    end

    always_comb begin
        state_nxt         = state;
        bgrant_nxt        = bgrant;
        owner_nxt         = owner;
        owner_valid_nxt   = owner_valid;
        last_owner_nxt    = last_owner;
        hold_timeout_nxt  = 1'b0;
        hold_cnt_nxt      = hold_cnt;
        split_pending_nxt = split_pending & ~released;
        resume_nxt        = resume | released;
        for (int m = 0; m < NUM_MASTERS; m++) split_slave_nxt[m] = split_slave[m];

        case (state)
            ARB_IDLE: begin
                if (elg_found) begin
                    bgrant_nxt         = '0;
                    bgrant_nxt[winner] = 1'b1;
                    owner_nxt          = winner;
                    owner_valid_nxt    = 1'b1;
                    last_owner_nxt     = winner;
                    resume_nxt[winner] = 1'b0;
                    hold_cnt_nxt       = '0;
                    state_nxt          = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (split_hit) begin
                    split_pending_nxt[owner] = 1'b1;
                    split_slave_nxt[owner]   = bus.sel_slave;
                    bgrant_nxt               = '0;
                    owner_valid_nxt          = 1'b0;
                    state_nxt                = ARB_HANDOVER;
                end else if (!bus.breq[owner]) begin
                    bgrant_nxt      = '0;
                    owner_valid_nxt = 1'b0;
                    state_nxt       = ARB_HANDOVER;
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST && contended) begin
                    bgrant_nxt       = '0;
                    owner_valid_nxt  = 1'b0;
                    hold_timeout_nxt = 1'b1;
                    state_nxt        = ARB_HANDOVER;
                end else if (hold_cnt != HOLD_LAST) begin
                    // Saturate so an uncontended owner is never cut off.
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end
            ARB_HANDOVER: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt       = ARB_IDLE;
                bgrant_nxt      = '0;
                owner_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.bgrant       = bgrant;
    assign bus.split        = split_pending;
    assign bus.owner        = owner;
    assign bus.owner_valid  = owner_valid;
    assign bus.hold_timeout = hold_timeout;

endmodule

// File: tb/tb_bus_arbiter_split.sv
// Directed bench: round-robin arbiter with hold limit plus a fixed-priority copy.
module tb_bus_arbiter_split;
    import bus_arb_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bus_arbiter_split_if #(.NUM_MASTERS(4), .NUM_SLAVES(4)) bif ();
    bus_arbiter_split_if #(.NUM_MASTERS(4), .NUM_SLAVES(4)) fif ();

    bus_arbiter_split #(.NUM_MASTERS(4), .NUM_SLAVES(4), .RR_EN(1'b1), .MAX_HOLD(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    bus_arbiter_split #(.NUM_MASTERS(4), .NUM_SLAVES(4), .RR_EN(1'b0), .MAX_HOLD(0)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (fif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.breq = '0; bif.sel_slave = '0; bif.slave_split = '0; bif.split_release = '0;
        fif.breq = '0; fif.sel_slave = '0; fif.slave_split = '0; fif.split_release = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_bgrant", 32'(bif.bgrant), 32'h0);
        chk("rst_split", 32'(bif.split), 32'h0);
        chk("rst_owner", 32'(bif.owner), 32'h0);
        chk("rst_valid", 32'(bif.owner_valid), 32'h0);
        chk("rst_timeout", 32'(bif.hold_timeout), 32'h0);
        rst = 1'b0;

        // Basic grant and release
        bif.breq = 4'b0001;
        tick();
        chk("basic_grant", 32'(bif.bgrant), 32'h1);
        chk("basic_valid", 32'(bif.owner_valid), 32'h1);
        chk("basic_owner", 32'(bif.owner), 32'h0);
        tick(); tick(); tick();
        chk("basic_hold", 32'(bif.bgrant), 32'h1);
        bif.breq = 4'b0000;
        tick();
        chk("basic_release", 32'(bif.bgrant), 32'h0);
        chk("basic_rel_valid", 32'(bif.owner_valid), 32'h0);

        // Round-robin fairness: order 0,1,2,3,0 with 2-cycle gaps
        do_reset();
        bif.breq = 4'hF;
        tick();
        for (int g = 0; g < 5; g++) begin
            int e;
            e = g % 4;
            chk("rr_grant", 32'(bif.bgrant), 32'(1 << e));
            chk("rr_owner", 32'(bif.owner), 32'(e));
            tick(); tick();
            bif.breq[2'(e)] = 1'b0;
            tick();
            chk("rr_gap1", 32'(bif.bgrant), 32'h0);
            bif.breq[2'(e)] = 1'b1;
            tick();
            chk("rr_gap2", 32'(bif.bgrant), 32'h0);
            tick();
        end
        bif.breq = '0;

        // Fixed priority: master 0 always wins
        do_reset();
        fif.breq = 4'hF;
        tick();
        for (int g = 0; g < 3; g++) begin
            chk("fp_grant", 32'(fif.bgrant), 32'h1);
            tick(); tick();
            fif.breq[0] = 1'b0;
            tick();
            chk("fp_gap", 32'(fif.bgrant), 32'h0);
            fif.breq[0] = 1'b1;
            tick();
            tick();
        end
        fif.breq = '0;

        // Split and resume
        do_reset();
        bif.breq = 4'b0011;
        bif.sel_slave = 2'd1;
        tick();
        chk("sp_own0", 32'(bif.bgrant), 32'h1);
        tick();
        bif.slave_split = 4'b0010;
        tick();
        bif.slave_split = '0;
        chk("sp_split", 32'(bif.split), 32'h1);
        chk("sp_revoke", 32'(bif.bgrant), 32'h0);
        tick();
        tick();
        chk("sp_own1", 32'(bif.bgrant), 32'h2);
        bif.split_release = 4'b0010;
        bif.breq = 4'b0111;
        tick();
        bif.split_release = '0;
        chk("sp_released", 32'(bif.split), 32'h0);
        bif.breq = 4'b0101;
        tick(); tick(); tick();
        chk("sp_resume_first", 32'(bif.bgrant), 32'h1);
        bif.breq = 4'b0100;
        tick(); tick(); tick();
        chk("sp_then_m2", 32'(bif.bgrant), 32'h4);
        bif.breq = '0;

        // Hold limit under contention
        do_reset();
        bif.breq = 4'b0011;
        tick();
        chk("hl_grant0", 32'(bif.bgrant), 32'h1);
        for (int c = 2; c <= 8; c++) begin
            tick();
            chk("hl_held", 32'(bif.bgrant), 32'h1);
            chk("hl_no_to", 32'(bif.hold_timeout), 32'h0);
        end
        tick();
        chk("hl_timeout", 32'(bif.hold_timeout), 32'h1);
        chk("hl_revoked", 32'(bif.bgrant), 32'h0);
        tick();
        chk("hl_to_pulse", 32'(bif.hold_timeout), 32'h0);
        tick();
        chk("hl_grant1", 32'(bif.bgrant), 32'h2);

        // Alone on the bus: no timeout
        do_reset();
        bif.breq = 4'b0001;
        tick();
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("hl_alone", 32'(bif.bgrant), 32'h1);
            chk("hl_alone_to", 32'(bif.hold_timeout), 32'h0);
        end
        bif.breq = '0;

        // Simultaneous split and release on slave 2
        do_reset();
        bif.breq = 4'b0011;
        bif.sel_slave = 2'd2;
        tick();
        bif.slave_split = 4'b0100;
        tick();
        bif.slave_split = '0;
        chk("sim_split0", 32'(bif.split), 32'h1);
        tick(); tick();
        chk("sim_own1", 32'(bif.bgrant), 32'h2);
        bif.slave_split = 4'b0100;
        bif.split_release = 4'b0100;
        tick();
        bif.slave_split = '0;
        bif.split_release = '0;
        chk("sim_swap", 32'(bif.split), 32'h2);
        tick(); tick();
        chk("sim_resume0", 32'(bif.bgrant), 32'h1);
        bif.slave_split = 4'b0100;
        bif.breq = 4'b0010;
        tick();
        bif.slave_split = '0;
        chk("sim_split_drop", 32'(bif.split), 32'h3);
        chk("sim_drop_grant", 32'(bif.bgrant), 32'h0);

        // Asynchronous reset mid-grant with splits pending
        bif.breq = 4'b0100;
        tick(); tick();
        chk("ar_grant2", 32'(bif.bgrant), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_bgrant", 32'(bif.bgrant), 32'h0);
        chk("ar_split", 32'(bif.split), 32'h0);
        chk("ar_valid", 32'(bif.owner_valid), 32'h0);
        #1;
        rst = 1'b0;
        bif.breq = 4'b0101;
        tick();
        chk("ar_next_m0", 32'(bif.bgrant), 32'h1);
        bif.breq = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
